// File: rtl/price_credit_formatter.sv
// Converts binary price/credit (cents) to eight DD.CC seven-segment digit codes
// using a parallel sequential double-dabble, leading-zero blanking and credit blink.
module price_credit_formatter #(
  parameter int VAL_BITS  = 14,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [VAL_BITS-1:0] price,
  input  logic [VAL_BITS-1:0] credit,
  input  logic                blink,
  output logic                busy,
  output logic                done,
  output logic [5:0]          D7,
  output logic [5:0]          D6,
  output logic [5:0]          D5,
  output logic [5:0]          D4,
  output logic [5:0]          D3,
  output logic [5:0]          D2,
  output logic [5:0]          D1,
  output logic [5:0]          D0
);

  localparam int IW = $clog2(VAL_BITS + 1);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [23:0] BLANK_FIELD = {4{6'h01}};
  localparam logic [23:0] EN_MASK     = 24'h7DF7DF;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              state;
  logic [VAL_BITS-1:0] p_bin, c_bin;
  logic [15:0]         p_bcd, c_bcd;
  logic [15:0]         p_adj, c_adj;
  logic [IW-1:0]       iter;
  logic [23:0]         p_hold, c_hold;
  logic [CW-1:0]       blink_cnt;
  logic                phase;

  function automatic logic [VAL_BITS-1:0] saturate(input logic [VAL_BITS-1:0] v);
    if (32'(v) > 32'd9999) return VAL_BITS'(9999);
    return v;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // {en, hex, dp_n} per digit; tens-of-dollars blanks on zero, DP after dollars.
  function automatic logic [23:0] format(input logic [15:0] b);
    logic [5:0] d3;
    d3 = (b[15:12] == 4'd0) ? 6'h01 : {1'b1, b[15:12], 1'b1};
    return {d3, 1'b1, b[11:8], 1'b0, 1'b1, b[7:4], 1'b1, 1'b1, b[3:0], 1'b1};
  endfunction

  assign p_adj = adjust(p_bcd);
  assign c_adj = adjust(c_bcd);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      iter   <= '0;
      p_bin  <= '0;
      c_bin  <= '0;
      p_bcd  <= '0;
      c_bcd  <= '0;
      p_hold <= BLANK_FIELD;
      c_hold <= BLANK_FIELD;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            p_bin <= saturate(price);
            c_bin <= saturate(credit);
            p_bcd <= '0;
            c_bcd <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          p_bcd <= {p_adj[14:0], p_bin[VAL_BITS-1]};
          c_bcd <= {c_adj[14:0], c_bin[VAL_BITS-1]};
          p_bin <= p_bin << 1;
          c_bin <= c_bin << 1;
          iter  <= iter + 1'b1;
          if (iter == IW'(VAL_BITS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          p_hold <= format(p_bcd);
          c_hold <= format(c_bcd);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Output stage: one register after the hold codes, with credit enables gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      {D7, D6, D5, D4} <= BLANK_FIELD;
      {D3, D2, D1, D0} <= BLANK_FIELD;
    end else begin
      {D7, D6, D5, D4} <= p_hold;
      {D3, D2, D1, D0} <= (blink && phase) ? (c_hold & EN_MASK) : c_hold;
    end
  end

endmodule

// File: tb/tb_price_credit_formatter.sv
// Randomized self-checking bench for price_credit_formatter against a decimal
// arithmetic model of the display; BLINK_DIV shortened to 4 clocks.
module tb_price_credit_formatter;

  localparam int VB = 14;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset, load, blink;
  logic [VB-1:0] price, credit;
  logic          busy, done;
  logic [5:0]    D7, D6, D5, D4, D3, D2, D1, D0;

  int checks = 0;
  int errors = 0;
  int unsigned m;
  logic [23:0] mp, mc;

  localparam logic [23:0] BLANK = {4{6'h01}};

  price_credit_formatter #(.VAL_BITS(VB), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .load(load), .price(price), .credit(credit),
    .blink(blink), .busy(busy), .done(done),
    .D7(D7), .D6(D6), .D5(D5), .D4(D4), .D3(D3), .D2(D2), .D1(D1), .D0(D0)
  );

  always #5 clk = ~clk;

  // Clocks since reset, used to predict the blink phase.
  always @(posedge clk) begin
    if (reset) m <= 0;
    else m <= m + 1;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fmt(input int v);
    int s, t, d, tc, c;
    logic [5:0] d3;
    s  = (v > 9999) ? 9999 : v;
    t  = s / 1000;
    d  = (s / 100) % 10;
    tc = (s / 10) % 10;
    c  = s % 10;
    d3 = (t == 0) ? 6'h01 : {1'b1, t[3:0], 1'b1};
    return {d3, 1'b1, d[3:0], 1'b0, 1'b1, tc[3:0], 1'b1, 1'b1, c[3:0], 1'b1};
  endfunction

  function automatic logic [23:0] gated(input logic [23:0] f);
    logic [23:0] r;
    r = f;
    if (blink && m > 0 && (((m - 1) / BD) % 2) == 1)
      for (int i = 0; i < 4; i++) r[6*i+5] = 1'b0;
    return r;
  endfunction

  task automatic check_out(input string tag);
    check(tag, {D7, D6, D5, D4, D3, D2, D1, D0}, {mp, gated(mc)});
  endtask

  // Called at a negedge; returns at the negedge after the done cycle's edge.
  task automatic do_load(input int p, input int c, input bit intrude);
    price  = VB'(p);
    credit = VB'(c);
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_start", {46'd0, busy, done}, {46'd0, 2'b10});
    check_out("hold_start");
    for (int i = 1; i <= VB + 1; i++) begin
      if (intrude && i == 5) begin
        price  = VB'($urandom_range(0, 16383));
        credit = VB'($urandom_range(0, 16383));
        load   = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      check($sformatf("busy_done_c%0d", i), {46'd0, busy, done},
            {46'd0, (i == VB + 1) ? 2'b01 : 2'b10});
      check_out($sformatf("stable_c%0d", i));
    end
    mp = fmt(p);
    mc = fmt(c);
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    check({tag, "_idle"}, {46'd0, busy, done}, 48'd0);
    check_out(tag);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; blink = 1'b0; price = '0; credit = '0;
    mp = BLANK; mc = BLANK;
    repeat (2) @(negedge clk);
    check("reset_flags", {46'd0, busy, done}, 48'd0);
    check("reset_digits", {D7, D6, D5, D4, D3, D2, D1, D0}, {BLANK, BLANK});
    reset = 1'b0;
    settle("post_reset");

    do_load(1050, 125, 1'b0);
    settle("d_1050_125");
    check("const_1050_125", {D7, D6, D5, D4, D3, D2, D1, D0},
          {6'h23, 6'h20, 6'h2B, 6'h21, 6'h01, 6'h22, 6'h25, 6'h2B});

    do_load(0, 0, 1'b0);
    settle("d_zero");
    check("const_zero", {D7, D6, D5, D4, D3, D2, D1, D0},
          {6'h01, 6'h20, 6'h21, 6'h21, 6'h01, 6'h20, 6'h21, 6'h21});

    do_load(9999, 12000, 1'b0);
    settle("d_sat");
    check("const_sat", {D7, D6, D5, D4, D3, D2, D1, D0}, {2{6'h33, 6'h32, 6'h33, 6'h33}});

    do_load(16383, 10000, 1'b0);
    settle("d_sat_max");

    do_load(4321, 987, 1'b1);
    settle("d_ignored_load");

    // Back-to-back: second load lands on the done cycle.
    do_load(2468, 1357, 1'b0);
    do_load(99, 5, 1'b0);
    settle("d_back_to_back");

    blink = 1'b1;
    do_load(1050, 125, 1'b0);
    for (int i = 0; i < 4 * BD; i++) settle($sformatf("blink_%0d", i));
    blink = 1'b0;
    settle("blink_off");

    for (int n = 0; n < 20; n++) begin
      blink = 1'(($urandom_range(0, 1)));
      do_load(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
              1'(($urandom_range(0, 3) == 0)));
      repeat (int'($urandom_range(1, 3))) settle($sformatf("rand_%0d", n));
    end
    blink = 1'b0;

    // Reset at cycle 7 of a conversion discards it.
    price = VB'(3333); credit = VB'(4444); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_flags", {46'd0, busy, done}, 48'd0);
    check("midreset_digits", {D7, D6, D5, D4, D3, D2, D1, D0}, {BLANK, BLANK});
    reset = 1'b0;
    mp = BLANK; mc = BLANK;
    for (int i = 0; i < VB + 6; i++) settle($sformatf("after_reset_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/price_credit_formatter.md
Name: price_credit_formatter

Overview:
- Upstream stage of the 8-digit seven-segment driver.
- Converts the vending controller's binary price and credit values (cents) into eight registered 6-bit digit codes on D7..D0, which connect to the driver's I7..I0.
- Left field D7..D4 shows price as DD.CC; right field D3..D0 shows credit as DD.CC.
- Uses a sequential double-dabble binary-to-BCD conversion, leading-zero blanking and an optional credit-field blink.

Parameters:
- VAL_BITS, 14, width of the price and credit inputs; values above 9999 saturate.
- BLINK_DIV, 25_000_000, clocks per blink half-period.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe: capture price/credit and start conversion
- price  input  VAL_BITS  item price in cents
- credit  input  VAL_BITS  inserted credit in cents
- blink  input  1  when high, credit field flashes
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when new digits are committed
- D7..D0  output  6 each  digit code {en, hex[3:0], dp_n}: en=1 lights the digit; dp_n=0 lights the decimal point (active-low)

Behaviour:
- Reset:
  - Conversion aborts; busy=0, done=0; blink counter and phase cleared.
  - D7..D0 = 6'h01 (digit off, DP off).
  - Stored BCD is cleared; outputs stay blank until the first completed conversion.
- States: IDLE, CONV, COMMIT.
- IDLE:
  - load=1 at edge k latches min(price,9999) and min(credit,9999) and clears the BCD shift registers.
  - busy=1 after edge k; go to CONV.
  - load while busy is ignored; no queuing.
- CONV:
  - Price and credit convert in parallel, one double-dabble iteration per clock.
  - Each iteration adds 3 to any BCD nibble >=5, then shifts left one bit (MSB first).
  - Exactly VAL_BITS iterations, on edges k+1..k+VAL_BITS, then go to COMMIT.
- COMMIT (edge k+VAL_BITS+1):
  - Formatted codes are written to the digit hold registers; busy=0, done=1 for one cycle; return to IDLE.
  - Latency is load to new digits = VAL_BITS+1 clocks (15 at default).
  - A load on the done cycle is accepted.
- Formatting, per field, digits [3]=tens of dollars, [2]=dollars, [1]=tens of cents, [0]=cents:
  - Digit [3] is blanked (en=0, hex=0, dp_n=1) when its BCD is 0.
  - Digits [2..0] always have en=1.
  - dp_n=0 on digit [2] only; all other digits have dp_n=1.
  - Price maps to D7..D4; credit maps to D3..D0.
- Saturation: an input >9999 is treated as 9999 (displays 99.99). No error indication.
- Blink:
  - Free-running counter counts 0..BLINK_DIV-1; phase toggles on wrap.
  - Outputs are registered each clock: D3..D0 = hold code, with en forced to 0 when blink=1 and phase=1.
  - D7..D4 are never blinked.
  - Blink gating adds 1 clock of latency.
  - Deasserting blink restores the credit digits on the next clock.
- Held digits remain stable during CONV; outputs change only at COMMIT (plus 1 register stage) or under blink gating.
- Reset mid-CONV returns to IDLE with blank outputs; the in-flight value is discarded.

Test Plan:
- Reset, then load price=1050, credit=125:
  - busy high for 15 cycles, done pulse at cycle 15.
  - D7..D4 = 23,20,2B,21 (hex).
  - D3..D0 = 01,22,25,2B (" 1.25").
- Load price=0, credit=0:
  - D7..D4 = 01,20,21,21.
  - D3..D0 = 01,20,21,21 (" 0.00").
- Load credit=12000, price=9999:
  - Both fields show 33,32,33,33 (99.99, saturated).
- Second load asserted 5 cycles into a conversion:
  - Ignored; done fires once, at cycle 15 after the first load.
  - Outputs reflect the first values only.
- BLINK_DIV=4, blink=1, credit=125:
  - D3..D0 alternate between 01,22,25,2B and 01,02,05,0B every 4 clocks.
  - D7..D4 stay constant.
- Reset asserted at cycle 7 of a conversion:
  - Next clock: busy=0, D7..D0 all 01.
  - No done pulse.
